// File: rtl/hit_judge.sv
// Two-track hit judgment, lockout, score/combo/max-combo and timed result code.
// Define JUDGE_DEBOUNCE_EN to add a 2-flop synchronizer and tick-based debouncer per button.
module hit_judge #(
  parameter int PERFECT_PTS    = 10,
  parameter int NORMAL_PTS     = 5,
  parameter int SCORE_W        = 16,
  parameter int COMBO_W        = 8,
  parameter int LOCKOUT_MS     = 100,
  parameter int RESULT_HOLD_MS = 500,
  parameter int DEBOUNCE_MS    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_btn_t1,
  input  logic               i_btn_t2,
  input  logic               i_hit_t1,
  input  logic               i_hit_t2,
  input  logic               i_pre_hit_t1,
  input  logic               i_pre_hit_t2,
  input  logic               i_miss_t1,
  input  logic               i_miss_t2,
  output logic               o_clear_t1_perf,
  output logic               o_clear_t1_norm,
  output logic               o_clear_t2_perf,
  output logic               o_clear_t2_norm,
  output logic [SCORE_W-1:0] o_score,
  output logic [COMBO_W-1:0] o_combo,
  output logic [COMBO_W-1:0] o_max_combo,
  output logic [1:0]         o_result,
  output logic               o_result_valid
);
  localparam int LW = $clog2(LOCKOUT_MS + 1);
  localparam int HW = $clog2(RESULT_HOLD_MS + 1);
  localparam logic [LW-1:0]    LOCK_LOAD = LW'(LOCKOUT_MS);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(RESULT_HOLD_MS);
  localparam logic [SCORE_W:0] PERF_ADD  = (SCORE_W+1)'(PERFECT_PTS);
  localparam logic [SCORE_W:0] NORM_ADD  = (SCORE_W+1)'(NORMAL_PTS);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  logic [1:0] w_btn_raw, w_hit, w_pre, w_miss_raw;
  logic [1:0] w_lvl, w_press, w_perf, w_norm;
  logic [1:0] r_prev, r_miss;
  state_t     r_state [2];
  logic [LW-1:0] r_lock_cnt [2];
  logic [HW-1:0] r_hold;

  assign w_btn_raw  = {i_btn_t2, i_btn_t1};
  assign w_hit      = {i_hit_t2, i_hit_t1};
  assign w_pre      = {i_pre_hit_t2, i_pre_hit_t1};
  assign w_miss_raw = {i_miss_t2, i_miss_t1};

`ifdef JUDGE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);
  logic [1:0]    r_sync1, r_sync2, r_deb;
  logic [DW-1:0] r_db_cnt [2];

  // Levels reset high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 2'b11;
      r_sync2     <= 2'b11;
      r_deb       <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int t = 0; t < 2; t++) begin
        if (r_sync2[t] == r_deb[t]) begin
          r_db_cnt[t] <= '0;
        end else if (i_tick) begin
          if (r_db_cnt[t] == DB_LAST) begin
            r_deb[t]    <= r_sync2[t];
            r_db_cnt[t] <= '0;
          end else begin
            r_db_cnt[t] <= r_db_cnt[t] + DW'(1);
          end
        end
      end
    end
  end
  assign w_lvl = r_deb;
`else
  logic [1:0] r_btn;
  logic       w_unused_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_btn <= 2'b11;
    else        r_btn <= w_btn_raw;
  end
  assign w_lvl       = r_btn;
  assign w_unused_db = (DEBOUNCE_MS != 0);
`endif

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      w_press[t] = w_lvl[t] & ~r_prev[t];
      w_perf[t]  = w_press[t] && (r_state[t] == S_IDLE) && w_hit[t];
      w_norm[t]  = w_press[t] && (r_state[t] == S_IDLE) && !w_hit[t] && w_pre[t];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev          <= 2'b11;
      r_miss          <= 2'b00;
      o_clear_t1_perf <= 1'b0;
      o_clear_t1_norm <= 1'b0;
      o_clear_t2_perf <= 1'b0;
      o_clear_t2_norm <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        r_state[t]    <= S_IDLE;
        r_lock_cnt[t] <= '0;
      end
    end else begin
      r_prev          <= w_lvl;
      r_miss          <= w_miss_raw;
      o_clear_t1_perf <= w_perf[0];
      o_clear_t1_norm <= w_norm[0];
      o_clear_t2_perf <= w_perf[1];
      o_clear_t2_norm <= w_norm[1];
      for (int t = 0; t < 2; t++) begin
        if (r_state[t] == S_IDLE) begin
          if (w_perf[t] || w_norm[t]) begin
            r_state[t]    <= S_LOCK;
            r_lock_cnt[t] <= LOCK_LOAD;
          end
        end else begin
          if (r_lock_cnt[t] == '0)  r_state[t]    <= S_IDLE;
          else if (i_tick)          r_lock_cnt[t] <= r_lock_cnt[t] - LW'(1);
        end
      end
    end
  end

  logic [SCORE_W:0]   w_pts, w_score_sum;
  logic [1:0]         w_hits;
  logic [COMBO_W:0]   w_combo_sum;
  logic [COMBO_W-1:0] w_combo_next;
  logic [1:0]         w_code;
  logic               w_any_miss, w_event;

  always_comb begin
    w_pts = '0;
    for (int t = 0; t < 2; t++) begin
      if (w_perf[t])      w_pts = w_pts + PERF_ADD;
      else if (w_norm[t]) w_pts = w_pts + NORM_ADD;
    end
  end

  assign w_score_sum  = {1'b0, o_score} + w_pts;
  assign w_hits       = 2'(w_perf[0] | w_norm[0]) + 2'(w_perf[1] | w_norm[1]);
  assign w_combo_sum  = {1'b0, o_combo} + (COMBO_W+1)'(w_hits);
  assign w_any_miss   = |r_miss;
  // A miss wins over any hit judged in the same cycle, but the hit's points still count.
  assign w_combo_next = w_any_miss ? '0 : (w_combo_sum[COMBO_W] ? '1 : w_combo_sum[COMBO_W-1:0]);
  assign w_code       = w_any_miss ? 2'd3 : (|w_norm ? 2'd2 : (|w_perf ? 2'd1 : 2'd0));
  assign w_event      = w_any_miss | (|w_perf) | (|w_norm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_score        <= '0;
      o_combo        <= '0;
      o_max_combo    <= '0;
      o_result       <= 2'd0;
      o_result_valid <= 1'b0;
      r_hold         <= '0;
    end else begin
      o_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
      o_combo <= w_combo_next;
      if (w_combo_next > o_max_combo) o_max_combo <= w_combo_next;
      if (w_event) begin
        o_result       <= w_code;
        o_result_valid <= 1'b1;
        r_hold         <= HOLD_LOAD;
      end else if (o_result_valid) begin
        if (r_hold == '0) begin
          o_result       <= 2'd0;
          o_result_valid <= 1'b0;
        end else if (i_tick) begin
          r_hold <= r_hold - HW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus pushes expected judgments, a monitor checks clear pulses.
module tb_hit_judge;
  localparam int PERFECT_PTS    = 10;
  localparam int NORMAL_PTS     = 5;
  localparam int SCORE_W        = 12;
  localparam int COMBO_W        = 8;
  localparam int LOCKOUT_MS     = 100;
  localparam int RESULT_HOLD_MS = 500;
  localparam int DEBOUNCE_MS    = 10;
  localparam int SCORE_MAX      = (1 << SCORE_W) - 1;
  localparam int COMBO_MAX      = (1 << COMBO_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, i_tick = 1'b0;
  logic i_btn_t1 = 1'b0, i_btn_t2 = 1'b0, i_hit_t1 = 1'b0, i_hit_t2 = 1'b0;
  logic i_pre_hit_t1 = 1'b0, i_pre_hit_t2 = 1'b0, i_miss_t1 = 1'b0, i_miss_t2 = 1'b0;
  logic o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm;
  logic [SCORE_W-1:0] o_score;
  logic [COMBO_W-1:0] o_combo, o_max_combo;
  logic [1:0] o_result;
  logic o_result_valid;
  logic [3:0] clr_act;

  hit_judge #(.PERFECT_PTS(PERFECT_PTS), .NORMAL_PTS(NORMAL_PTS), .SCORE_W(SCORE_W),
              .COMBO_W(COMBO_W), .LOCKOUT_MS(LOCKOUT_MS), .RESULT_HOLD_MS(RESULT_HOLD_MS),
              .DEBOUNCE_MS(DEBOUNCE_MS)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick),
    .i_btn_t1(i_btn_t1), .i_btn_t2(i_btn_t2), .i_hit_t1(i_hit_t1), .i_hit_t2(i_hit_t2),
    .i_pre_hit_t1(i_pre_hit_t1), .i_pre_hit_t2(i_pre_hit_t2),
    .i_miss_t1(i_miss_t1), .i_miss_t2(i_miss_t2),
    .o_clear_t1_perf(o_clear_t1_perf), .o_clear_t1_norm(o_clear_t1_norm),
    .o_clear_t2_perf(o_clear_t2_perf), .o_clear_t2_norm(o_clear_t2_norm),
    .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo),
    .o_result(o_result), .o_result_valid(o_result_valid));

  always #10 clk = ~clk;
  assign clr_act = {o_clear_t2_norm, o_clear_t2_perf, o_clear_t1_norm, o_clear_t1_perf};

  int n_tests = 0, n_fail = 0;

  // Reference model: game rules in plain integers, time measured in ticks elapsed.
  int m_score, m_combo, m_max, m_result, m_since_evt;
  bit m_valid;
  bit m_locked [2];
  int m_lock_ticks [2];

  typedef struct {
    logic [3:0] clr;
    int score, combo, maxc, result, valid;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_score"}, int'(o_score), m_score);
    chk({name, "_combo"}, int'(o_combo), m_combo);
    chk({name, "_max"},   int'(o_max_combo), m_max);
    chk({name, "_result"}, int'(o_result), m_result);
    chk({name, "_valid"}, int'(o_result_valid), int'(m_valid));
  endtask

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_max = 0; m_result = 0; m_since_evt = 0; m_valid = 0;
    for (int t = 0; t < 2; t++) begin m_locked[t] = 0; m_lock_ticks[t] = 0; end
  endtask

  task automatic do_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) i_tick = 1'b1;
      @(negedge clk) i_tick = 1'b0;
      repeat (gap) @(negedge clk);
      if (m_valid) begin
        m_since_evt++;
        if (m_since_evt >= RESULT_HOLD_MS) begin m_valid = 0; m_result = 0; end
      end
      for (int t = 0; t < 2; t++)
        if (m_locked[t]) begin
          m_lock_ticks[t]++;
          if (m_lock_ticks[t] >= LOCKOUT_MS) m_locked[t] = 0;
        end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_event(input bit b1, input bit h1, input bit p1, input bit m1,
                          input bit b2, input bit h2, input bit p2, input bit m2,
                          input string name);
    bit [1:0] b, h, p, m, perf, norm;
    int pts, hits, waited;
    exp_t e;
    b = {b2, b1}; h = {h2, h1}; p = {p2, p1}; m = {m2, m1};
    pts = 0; hits = 0;
    for (int t = 0; t < 2; t++) begin
      perf[t] = b[t] && !m_locked[t] && h[t];
      norm[t] = b[t] && !m_locked[t] && !h[t] && p[t];
      if (perf[t]) pts += PERFECT_PTS;
      if (norm[t]) pts += NORMAL_PTS;
      if (perf[t] || norm[t]) begin hits++; m_locked[t] = 1; m_lock_ticks[t] = 0; end
    end
    m_score = (m_score + pts > SCORE_MAX) ? SCORE_MAX : m_score + pts;
    if (m != 0) m_combo = 0;
    else m_combo = (m_combo + hits > COMBO_MAX) ? COMBO_MAX : m_combo + hits;
    if (m_combo > m_max) m_max = m_combo;
    if (m != 0 || hits > 0) begin
      m_result = (m != 0) ? 3 : ((norm != 0) ? 2 : 1);
      m_valid = 1; m_since_evt = 0;
    end
    e.clr = {norm[1], perf[1], norm[0], perf[0]};
    e.score = m_score; e.combo = m_combo; e.maxc = m_max;
    e.result = m_result; e.valid = int'(m_valid);
    @(negedge clk);
    if (e.clr != 4'b0) sb_q.push_back(e);
    i_hit_t1 = h[0]; i_pre_hit_t1 = p[0]; i_btn_t1 = b[0]; i_miss_t1 = m[0];
    i_hit_t2 = h[1]; i_pre_hit_t2 = p[1]; i_btn_t2 = b[1]; i_miss_t2 = m[1];
    @(negedge clk);
    i_miss_t1 = 1'b0; i_miss_t2 = 1'b0;
    @(negedge clk);
    i_btn_t1 = 1'b0; i_btn_t2 = 1'b0;
    if (e.clr == 4'b0) check_state(name);
    else begin
      waited = 0;
      while (sb_q.size() != 0 && waited < 4) begin @(negedge clk); waited++; end
      if (sb_q.size() != 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: clear pulse pending=%0d expected 0", name, sb_q.size());
        sb_q.delete();
      end
    end
    repeat (2) @(negedge clk);
    i_hit_t1 = 1'b0; i_pre_hit_t1 = 1'b0; i_hit_t2 = 1'b0; i_pre_hit_t2 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && clr_act != 4'b0) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_clear: got %b expected 0000", clr_act);
      end else begin
        e = sb_q.pop_front();
        chk("mon_clear",  int'(clr_act), int'(e.clr));
        chk("mon_score",  int'(o_score), e.score);
        chk("mon_combo",  int'(o_combo), e.combo);
        chk("mon_max",    int'(o_max_combo), e.maxc);
        chk("mon_result", int'(o_result), e.result);
        chk("mon_valid",  int'(o_result_valid), e.valid);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_state("init");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_event(1, 1, 0, 0, 0, 0, 0, 0, "perf");
    chk("perf_score", int'(o_score), 10);
    chk("perf_combo", int'(o_combo), 1);
    chk("perf_result", int'(o_result), 1);
    do_ticks(RESULT_HOLD_MS - 1, 1);
    check_state("hold_edge");
    do_ticks(1, 1);
    check_state("hold_done");
    chk("hold_done_valid", int'(o_result_valid), 0);

    do_event(0, 0, 0, 0, 1, 0, 1, 0, "norm");
    chk("norm_score", int'(o_score), 15);
    chk("norm_result", int'(o_result), 2);
    do_event(1, 0, 0, 0, 0, 0, 0, 0, "empty");

    do_event(1, 1, 0, 0, 0, 0, 0, 0, "lock_first");
    do_ticks(50, 1);
    do_event(1, 1, 0, 0, 0, 0, 0, 0, "lock_ignored");
    chk("lock_ignored_score", int'(o_score), 25);
    do_ticks(51, 1);
    do_event(1, 1, 0, 0, 0, 0, 0, 0, "lock_after");
    chk("lock_after_score", int'(o_score), 35);

    do_ticks(LOCKOUT_MS + 1, 0);
    do_event(1, 1, 0, 1, 1, 0, 1, 0, "simul");
    chk("simul_score", int'(o_score), 50);
    chk("simul_combo", int'(o_combo), 0);
    chk("simul_max", int'(o_max_combo), 4);
    chk("simul_result", int'(o_result), 3);

    do_ticks(LOCKOUT_MS + 1, 0);
    do_event(1, 1, 0, 0, 0, 0, 0, 0, "pre_miss");
    do_event(0, 0, 0, 0, 0, 0, 0, 1, "miss_only");
    chk("miss_only_result", int'(o_result), 3);

    for (int i = 0; i < 40; i++) begin
      do_event($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0, "rand");
      do_ticks($urandom_range(0, 120), $urandom_range(0, 2));
      check_state("rand_idle");
    end

    do_ticks(LOCKOUT_MS + 1, 0);
    for (int i = 0; i < 205; i++) begin
      do_event(1, 1, 0, 0, 1, 1, 0, 0, "sat");
      do_ticks(LOCKOUT_MS + 1, 0);
    end
    chk("sat_combo", int'(o_combo), 255);
    chk("sat_max", int'(o_max_combo), 255);
    chk("sat_score", int'(o_score), SCORE_MAX);

    do_event(1, 1, 0, 0, 0, 0, 0, 0, "rst_lock");
    @(negedge clk);
    i_btn_t1 = 1'b1; i_hit_t1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("rst_async");
    chk("rst_clear", int'(clr_act), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("rst_held");
    i_btn_t1 = 1'b0; i_hit_t1 = 1'b0;
    repeat (2) @(negedge clk);
    do_event(1, 1, 0, 0, 0, 0, 0, 0, "post_rst");
    chk("post_rst_score", int'(o_score), 10);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
